// File: rtl/jtkcpu_pkg.sv
// Shared KONAMI-1 definitions: CC bit positions, cc_op and int_type codes, interrupt FSM states.
// The debug override in jtkcpu_ccreg is enabled by the JTKCPU_CCREG_DEBUG_EN macro.
package jtkcpu_pkg;

    localparam int CC_E_BIT = 7;
    localparam int CC_F_BIT = 6;
    localparam int CC_H_BIT = 5;
    localparam int CC_I_BIT = 4;
    localparam int CC_N_BIT = 3;
    localparam int CC_Z_BIT = 2;
    localparam int CC_V_BIT = 1;
    localparam int CC_C_BIT = 0;

    localparam logic [2:0] CC_OP_NONE  = 3'd0;
    localparam logic [2:0] CC_OP_ANDCC = 3'd1;
    localparam logic [2:0] CC_OP_ORCC  = 3'd2;
    localparam logic [2:0] CC_OP_LOAD  = 3'd3;
    localparam logic [2:0] CC_OP_CWAI  = 3'd4;

    localparam logic [1:0] INT_NMI  = 2'd0;
    localparam logic [1:0] INT_FIRQ = 2'd1;
    localparam logic [1:0] INT_IRQ  = 2'd2;
    localparam logic [1:0] INT_SWI  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_MASK = 2'd2
    } int_state_t;

    // Mask bits applied once the CC byte has been stacked: I always, F unless plain IRQ.
    function automatic logic [7:0] int_mask_bits(input logic [1:0] int_type);
        logic [7:0] m;
        m = 8'h00;
        m[CC_I_BIT] = 1'b1;
        if (int_type != INT_IRQ) m[CC_F_BIT] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/jtkcpu_ccreg_if.sv
// Bus between the CPU sequencer (master) and the condition-code register (slave).
// Stacking handshake: stk_req stays high with stk_data stable until stk_ack is sampled on a cen edge.
interface jtkcpu_ccreg_if;
    import jtkcpu_pkg::*;

    logic             cen;
    logic [7:0]       alu_flags;
    logic [7:0]       alu_mask;
    logic [2:0]       cc_op;
    logic [7:0]       imm;
    logic             int_req;
    logic [1:0]       int_type;
    logic             stk_ack;
    logic [7:0]       cc;
    logic             stk_req;
    logic [7:0]       stk_data;
    logic             int_busy;
    logic             int_done;
    int_state_t       fsm_state;

    modport master (
        output cen, alu_flags, alu_mask, cc_op, imm, int_req, int_type, stk_ack,
        input  cc, stk_req, stk_data, int_busy, int_done, fsm_state
    );

    modport slave (
        input  cen, alu_flags, alu_mask, cc_op, imm, int_req, int_type, stk_ack,
        output cc, stk_req, stk_data, int_busy, int_done, fsm_state
    );

endinterface

// File: rtl/jtkcpu_ccreg.sv
// KONAMI-1 condition-code register: merges ALU/ANDCC/ORCC/LOAD/CWAI writes and runs interrupt entry.
// Define JTKCPU_CCREG_DEBUG_EN to add the dbg_wr/dbg_din CC override ports.
module jtkcpu_ccreg
    import jtkcpu_pkg::*;
#(
    parameter logic [7:0] RST_CC    = 8'h50,
    parameter int         FIRQ_FULL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef JTKCPU_CCREG_DEBUG_EN
    input  logic            dbg_wr,
    input  logic [7:0]      dbg_din,
`endif
    jtkcpu_ccreg_if.slave   bus
);

    int_state_t r_state;
    int_state_t w_state_nxt;
    logic [7:0] r_cc;
    logic [7:0] w_cc_nxt;
    logic [1:0] r_int_type;
    logic [1:0] w_int_type_nxt;
    logic       r_stk_req;
    logic       w_stk_req_nxt;
    logic       r_int_done;
    logic       w_int_done_nxt;
    logic       w_e_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (bus.cen) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc       <= RST_CC;
            r_int_type <= INT_NMI;
            r_stk_req  <= 1'b0;
            r_int_done <= 1'b0;
        end else if (bus.cen) begin
            r_cc       <= w_cc_nxt;
            r_int_type <= w_int_type_nxt;
            r_stk_req  <= w_stk_req_nxt;
            r_int_done <= w_int_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.int_req) w_state_nxt = ST_SAVE;
            ST_SAVE: if (bus.stk_ack) w_state_nxt = ST_MASK;
            ST_MASK: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FIRQ only marks a full-state entry when the core is built that way.
    always_comb begin
        w_e_entry      = (bus.int_type == INT_FIRQ) ? (FIRQ_FULL != 0) : 1'b1;
        w_cc_nxt       = r_cc;
        w_int_type_nxt = r_int_type;
        case (r_state)
            ST_IDLE: begin
                if (bus.int_req) begin
                    w_cc_nxt[CC_E_BIT] = w_e_entry;
                    w_int_type_nxt     = bus.int_type;
                end else begin
                    case (bus.cc_op)
                        CC_OP_ANDCC: w_cc_nxt = r_cc & bus.imm;
                        CC_OP_ORCC:  w_cc_nxt = r_cc | bus.imm;
                        CC_OP_LOAD:  w_cc_nxt = bus.imm;
                        CC_OP_CWAI:  w_cc_nxt = (r_cc & bus.imm) | 8'h80;
                        default:     w_cc_nxt = (r_cc & ~bus.alu_mask) | (bus.alu_flags & bus.alu_mask);
                    endcase
                end
            end
            ST_MASK: w_cc_nxt = r_cc | int_mask_bits(r_int_type);
            default: w_cc_nxt = r_cc;
        endcase
`ifdef JTKCPU_CCREG_DEBUG_EN
        if (dbg_wr) w_cc_nxt = dbg_din;
`endif
        w_stk_req_nxt  = (w_state_nxt == ST_SAVE);
        w_int_done_nxt = (r_state == ST_MASK);
    end

    assign bus.cc        = r_cc;
    assign bus.stk_data  = r_cc;
    assign bus.stk_req   = r_stk_req;
    assign bus.int_busy  = (r_state != ST_IDLE);
    assign bus.int_done  = r_int_done;
    assign bus.fsm_state = r_state;

endmodule

// File: tb/tb_jtkcpu_ccreg.sv
// Self-checking bench for jtkcpu_ccreg: directed vector table, interrupt sequences, random ops vs model.
// Exercises the debug override too when JTKCPU_CCREG_DEBUG_EN is defined.
module tb_jtkcpu_ccreg;
    import jtkcpu_pkg::*;

    localparam int         FIRQ_FULL = 0;
    localparam logic [7:0] RST_CC    = 8'h50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtkcpu_ccreg_if bus();
`ifdef JTKCPU_CCREG_DEBUG_EN
    logic       dbg_wr;
    logic [7:0] dbg_din;
`endif

    jtkcpu_ccreg #(.RST_CC(RST_CC), .FIRQ_FULL(FIRQ_FULL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef JTKCPU_CCREG_DEBUG_EN
        .dbg_wr  (dbg_wr),
        .dbg_din (dbg_din),
`endif
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_cc;

    typedef struct {
        logic [7:0] start;
        logic [2:0] op;
        logic [7:0] imm;
        logic [7:0] flags;
        logic [7:0] mask;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cen       = 1'b1;
        bus.alu_flags = 8'h00;
        bus.alu_mask  = 8'h00;
        bus.cc_op     = CC_OP_NONE;
        bus.imm       = 8'h00;
        bus.int_req   = 1'b0;
        bus.int_type  = INT_NMI;
        bus.stk_ack   = 1'b0;
`ifdef JTKCPU_CCREG_DEBUG_EN
        dbg_wr  = 1'b0;
        dbg_din = 8'h00;
`endif
    endtask

    // Reference: CC result of one IDLE edge, evaluated bit by bit from the operation rules.
    function automatic logic [7:0] ref_idle(input logic [7:0] cc, input logic [2:0] op, input logic [7:0] imm,
                                            input logic [7:0] flags, input logic [7:0] mask);
        logic [7:0] r;
        r = cc;
        case (op)
            3'd1: r = cc & imm;
            3'd2: r = cc | imm;
            3'd3: r = imm;
            3'd4: begin r = cc & imm; r[7] = 1'b1; end
            default: for (int i = 0; i < 8; i++) if (mask[i]) r[i] = flags[i];
        endcase
        return r;
    endfunction

    function automatic logic ref_e(input logic [1:0] t);
        return (t == 2'd1) ? (FIRQ_FULL != 0) : 1'b1;
    endfunction

    function automatic logic [7:0] ref_masked(input logic [7:0] cc, input logic [1:0] t);
        logic [7:0] r;
        r = cc;
        r[4] = 1'b1;
        if (t != 2'd2) r[6] = 1'b1;
        return r;
    endfunction

    task automatic load_cc(input logic [7:0] v);
        bus.cc_op = CC_OP_LOAD;
        bus.imm   = v;
        step();
        bus.cc_op = CC_OP_NONE;
        bus.imm   = 8'h00;
        m_cc = v;
    endtask

    task automatic do_int(input logic [1:0] t, input int delay, input bit hold);
        logic [7:0] exp_stk;
        logic [7:0] exp_fin;
        exp_stk    = m_cc;
        exp_stk[7] = ref_e(t);
        exp_fin    = ref_masked(exp_stk, t);
        exp_q.push_back(exp_stk);

        bus.int_req  = 1'b1;
        bus.int_type = t;
        bus.cc_op    = CC_OP_LOAD;
        bus.imm      = 8'hFF;
        step();
        bus.cc_op = CC_OP_NONE;
        if (!hold) bus.int_req = 1'b0;
        check8("entry_stk_req", {7'd0, bus.stk_req}, 8'd1);
        check8("entry_busy", {7'd0, bus.int_busy}, 8'd1);
        check8("entry_stk_data", bus.stk_data, exp_stk);

        for (int i = 0; i < delay; i++) begin
            bus.cc_op     = 3'($urandom_range(0, 7));
            bus.imm       = 8'($urandom);
            bus.alu_flags = 8'($urandom);
            bus.alu_mask  = 8'hFF;
            step();
            check8("save_hold_req", {7'd0, bus.stk_req}, 8'd1);
            check8("save_hold_data", bus.stk_data, exp_stk);
        end
        bus.cc_op    = CC_OP_NONE;
        bus.alu_mask = 8'h00;

        bus.cen     = 1'b0;
        bus.stk_ack = 1'b1;
        step();
        check8("save_cen0_req", {7'd0, bus.stk_req}, 8'd1);

        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            check8("sb_stk_data", bus.stk_data, exp_q.pop_front());
        end

        bus.cen     = 1'b1;
        bus.int_req = 1'b1;
        step();
        bus.stk_ack = 1'b0;
        if (!hold) bus.int_req = 1'b0;
        check8("ack_stk_req", {7'd0, bus.stk_req}, 8'd0);
        check8("ack_busy", {7'd0, bus.int_busy}, 8'd1);
        check8("ack_done", {7'd0, bus.int_done}, 8'd0);

        step();
        bus.int_req = 1'b0;
        check8("mask_done", {7'd0, bus.int_done}, 8'd1);
        check8("mask_cc", bus.cc, exp_fin);
        check8("mask_busy", {7'd0, bus.int_busy}, 8'd0);

        bus.cen = 1'b0;
        step();
        check8("done_cen0_hold", {7'd0, bus.int_done}, 8'd1);
        bus.cen = 1'b1;
        step();
        check8("done_clear", {7'd0, bus.int_done}, 8'd0);
        check8("idle_cc", bus.cc, exp_fin);
        m_cc = exp_fin;
    endtask

    initial begin
        vecs[0]  = '{8'h50, CC_OP_ANDCC, 8'hAF, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{8'h00, CC_OP_ORCC,  8'h05, 8'h00, 8'h00, 8'h05};
        vecs[2]  = '{8'h05, CC_OP_LOAD,  8'hA3, 8'h00, 8'h00, 8'hA3};
        vecs[3]  = '{8'h50, CC_OP_NONE,  8'h00, 8'h0C, 8'h0F, 8'h5C};
        vecs[4]  = '{8'h50, CC_OP_ORCC,  8'h01, 8'h0C, 8'h0F, 8'h51};
        vecs[5]  = '{8'hFF, CC_OP_CWAI,  8'h00, 8'h00, 8'h00, 8'h80};
        vecs[6]  = '{8'h12, CC_OP_CWAI,  8'hEF, 8'h00, 8'h00, 8'h82};
        vecs[7]  = '{8'hA5, CC_OP_NONE,  8'h00, 8'h00, 8'h00, 8'hA5};
        vecs[8]  = '{8'hA5, CC_OP_NONE,  8'h00, 8'h5A, 8'hFF, 8'h5A};
        vecs[9]  = '{8'h33, 3'd5,        8'hFF, 8'hCC, 8'hF0, 8'hC3};
        vecs[10] = '{8'h33, 3'd7,        8'h00, 8'h00, 8'h0F, 8'h30};
        vecs[11] = '{8'hF0, CC_OP_ANDCC, 8'h0F, 8'hFF, 8'hFF, 8'h00};

        idle_inputs();
        rst_n   = 1'b0;
        bus.cen = 1'b0;
        step();
        step();
        check8("rst_cc", bus.cc, 8'h50);
        check8("rst_stk_req", {7'd0, bus.stk_req}, 8'd0);
        check8("rst_busy", {7'd0, bus.int_busy}, 8'd0);
        check8("rst_done", {7'd0, bus.int_done}, 8'd0);
        rst_n   = 1'b1;
        bus.cen = 1'b1;
        step();
        check8("post_rst_cc", bus.cc, 8'h50);
        m_cc = 8'h50;

        for (int i = 0; i < 12; i++) begin
            load_cc(vecs[i].start);
            bus.cc_op     = vecs[i].op;
            bus.imm       = vecs[i].imm;
            bus.alu_flags = vecs[i].flags;
            bus.alu_mask  = vecs[i].mask;
            step();
            check8($sformatf("vec%0d", i), bus.cc, vecs[i].exp);
            idle_inputs();
            m_cc = vecs[i].exp;
        end

        bus.cen   = 1'b0;
        bus.cc_op = CC_OP_LOAD;
        bus.imm   = 8'h77;
        step();
        check8("cen0_hold_cc", bus.cc, m_cc);
        idle_inputs();

        load_cc(8'h00);
        do_int(INT_IRQ, 3, 1'b0);
        check8("irq_final", bus.cc, 8'h90);
        load_cc(8'h8F);
        do_int(INT_FIRQ, 0, 1'b1);
        check8("firq_final", bus.cc, 8'h5F);
        load_cc(8'h00);
        do_int(INT_NMI, 1, 1'b0);
        check8("nmi_final", bus.cc, 8'hD0);

        load_cc(8'h00);
        bus.int_req  = 1'b1;
        bus.int_type = INT_IRQ;
        step();
        bus.int_req = 1'b0;
        check8("pre_rst_stk_req", {7'd0, bus.stk_req}, 8'd1);
        rst_n = 1'b0;
        step();
        check8("rst_save_stk_req", {7'd0, bus.stk_req}, 8'd0);
        check8("rst_save_cc", bus.cc, 8'h50);
        check8("rst_save_busy", {7'd0, bus.int_busy}, 8'd0);
        rst_n = 1'b1;
        m_cc  = 8'h50;

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_int(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end else begin
                bus.cc_op     = 3'($urandom_range(0, 7));
                bus.imm       = 8'($urandom);
                bus.alu_flags = 8'($urandom);
                bus.alu_mask  = 8'($urandom);
                bus.cen       = ($urandom_range(0, 4) != 0);
                step();
                if (bus.cen) m_cc = ref_idle(m_cc, bus.cc_op, bus.imm, bus.alu_flags, bus.alu_mask);
                check8("rand_cc", bus.cc, m_cc);
                check8("rand_busy", {7'd0, bus.int_busy}, 8'd0);
                idle_inputs();
            end
        end

`ifdef JTKCPU_CCREG_DEBUG_EN
        dbg_wr    = 1'b1;
        dbg_din   = 8'h3C;
        bus.cc_op = CC_OP_LOAD;
        bus.imm   = 8'hFF;
        step();
        idle_inputs();
        check8("dbg_cc", bus.cc, 8'h3C);
        m_cc = 8'h3C;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
